// File: rtl/ps2_kbd_event_rx.sv
// ps2_kbd_event_rx
// PS/2 keyboard receiver and event decoder. The raw PS/2 lines are
// synchronised and run-length filtered. Frames are sampled on falling edges
// of the filtered clock and checked for odd parity and the stop bit. E0 and
// F0 prefixes are folded into make/break events, and typematic repeats that
// arrive inside a speed-dependent hold window are dropped. The resulting
// events are queued in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk/data    raw asynchronous PS/2 lines
//   speed_up/dn     saturating speed adjust pulses
//   ev_valid/ready  FIFO head handshake (pop on valid && ready)
//   ev_code/ext/break  head event fields
//   move_speed      current speed value
//   err_parity      1-cycle pulse on parity or stop-bit error
//   err_timeout     1-cycle pulse on frame timeout
//   overflow        1-cycle pulse when an event is lost to a full FIFO
module ps2_kbd_event_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLD_BASE      = 4000000,
  parameter int HOLD_STEP      = 500000,
  parameter int SPEED_W        = 3,
  parameter int SPEED_INIT     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               speed_up,
  input  logic               speed_dn,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic               ev_ext,
  output logic               ev_break,
  output logic [SPEED_W-1:0] move_speed,
  output logic               err_parity,
  output logic               err_timeout,
  output logic               overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int FCNT_W = $clog2(FILTER_LEN) + 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW     = 32;
  localparam logic [SPEED_W-1:0] SPEED_MAX = {SPEED_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, CHECK = 2'd2} state_t;

  // Odd parity holds when the XOR over data and parity bit is 1.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic [1:0]       clk_sync_r, data_sync_r;
  logic             clk_filt_r, data_filt_r, clk_filt_d_r;
  logic [FCNT_W-1:0] clk_cnt_r, data_cnt_r;
  logic             fall_s;

  state_t           state_r, state_next_s;
  logic [3:0]       bit_cnt_r;
  logic [TMO_W-1:0] tmo_r;
  logic             tmo_hit_s;
  logic [9:0]       shift_r;
  logic             ext_flag_r, brk_flag_r;
  logic             err_parity_r, err_timeout_r;

  logic [7:0]       rx_byte_s;
  logic             frame_ok_s, ev_new_s;
  logic [8:0]       ev_key_s;
  logic [HW-1:0]    hold_win_s, hold_cnt_r;
  logic [8:0]       last_key_r;
  logic             last_vld_r, drop_s, push_s, key_match_s;

  logic [9:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_s, full_s, wr_en_s, overflow_r;
  logic [9:0]       head_s;
  logic [SPEED_W-1:0] speed_r;

  // Two-flop synchronisers for both PS/2 lines (idle level is high).
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Run filter on the clock line: flip only after FILTER_LEN differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt_r   <= 1'b1;
      clk_cnt_r    <= '0;
      clk_filt_d_r <= 1'b1;
    end else begin
      clk_filt_d_r <= clk_filt_r;
      if (clk_sync_r[1] == clk_filt_r) begin
        clk_cnt_r <= '0;
      end else if (clk_cnt_r == FCNT_W'(FILTER_LEN - 1)) begin
        clk_filt_r <= clk_sync_r[1];
        clk_cnt_r  <= '0;
      end else begin
        clk_cnt_r <= clk_cnt_r + FCNT_W'(1);
      end
    end
  end

  // Run filter on the data line, same rule as the clock line.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_filt_r <= 1'b1;
      data_cnt_r  <= '0;
    end else begin
      if (data_sync_r[1] == data_filt_r) begin
        data_cnt_r <= '0;
      end else if (data_cnt_r == FCNT_W'(FILTER_LEN - 1)) begin
        data_filt_r <= data_sync_r[1];
        data_cnt_r  <= '0;
      end else begin
        data_cnt_r <= data_cnt_r + FCNT_W'(1);
      end
    end
  end

  assign fall_s = clk_filt_d_r & ~clk_filt_r;

  // Frame FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Frame FSM next-state logic; timeout has priority over the final edge.
  always_comb begin
    state_next_s = state_r;
    tmo_hit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (fall_s && !data_filt_r) begin
          state_next_s = RX;
        end else begin
          state_next_s = IDLE;
        end
      end
      RX: begin
        if (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          tmo_hit_s    = 1'b1;
          state_next_s = IDLE;
        end else if (fall_s && (bit_cnt_r == 4'd9)) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = RX;
        end
      end
      CHECK:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // shift_r[7:0] = data (LSB first), [8] = parity, [9] = stop.
  assign rx_byte_s  = shift_r[7:0];
  assign frame_ok_s = odd_parity_ok(shift_r[8:0]) && shift_r[9];
  assign ev_new_s   = (state_r == CHECK) && frame_ok_s &&
                      (rx_byte_s != 8'hE0) && (rx_byte_s != 8'hF0);
  assign ev_key_s   = {ext_flag_r, rx_byte_s};

  // Frame datapath: bit shifting, timeout counter, prefix flags, error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r     <= 4'd0;
      tmo_r         <= '0;
      shift_r       <= 10'd0;
      ext_flag_r    <= 1'b0;
      brk_flag_r    <= 1'b0;
      err_parity_r  <= 1'b0;
      err_timeout_r <= 1'b0;
    end else begin
      err_parity_r  <= 1'b0;
      err_timeout_r <= tmo_hit_s;
      case (state_r)
        IDLE: begin
          bit_cnt_r <= 4'd0;
          tmo_r     <= '0;
        end
        RX: begin
          tmo_r <= tmo_r + TMO_W'(1);
          if (fall_s && !tmo_hit_s) begin
            shift_r   <= {data_filt_r, shift_r[9:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        CHECK: begin
          if (!frame_ok_s) begin
            err_parity_r <= 1'b1;
            ext_flag_r   <= 1'b0;
            brk_flag_r   <= 1'b0;
          end else if (rx_byte_s == 8'hE0) begin
            ext_flag_r <= 1'b1;
          end else if (rx_byte_s == 8'hF0) begin
            brk_flag_r <= 1'b1;
          end else begin
            ext_flag_r <= 1'b0;
            brk_flag_r <= 1'b0;
          end
        end
        default: begin
          bit_cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Repeat filter decision for the event formed in CHECK.
  always_comb begin
    hold_win_s  = HW'(HOLD_BASE) - (HW'(speed_r) * HW'(HOLD_STEP));
    key_match_s = last_vld_r && (last_key_r == ev_key_s);
    if (ev_new_s && !brk_flag_r && key_match_s && (hold_cnt_r < hold_win_s)) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
    push_s = ev_new_s && !drop_s;
  end

  // Hold counter and last-make key; the counter also clamps if the window shrinks.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_r <= '0;
      last_key_r <= 9'd0;
      last_vld_r <= 1'b0;
    end else if (push_s && !brk_flag_r) begin
      hold_cnt_r <= '0;
      last_key_r <= ev_key_s;
      last_vld_r <= 1'b1;
    end else begin
      if (hold_cnt_r < hold_win_s) begin
        hold_cnt_r <= hold_cnt_r + HW'(1);
      end else begin
        hold_cnt_r <= hold_win_s;
      end
      if (push_s && brk_flag_r && key_match_s) begin
        last_vld_r <= 1'b0;
      end
    end
  end

  assign pop_s   = (count_r != CNT_W'(0)) && ev_ready;
  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign wr_en_s = push_s && (!full_s || pop_s);

  // FIFO storage; no reset needed because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= {ext_flag_r, brk_flag_r, rx_byte_s};
    end
  end

  // FIFO pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= push_s && full_s && !pop_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Saturating speed register; simultaneous up and down cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_r <= SPEED_W'(SPEED_INIT);
    end else begin
      case ({speed_up, speed_dn})
        2'b10:   if (speed_r != SPEED_MAX) speed_r <= speed_r + SPEED_W'(1);
        2'b01:   if (speed_r != SPEED_W'(0)) speed_r <= speed_r - SPEED_W'(1);
        default: speed_r <= speed_r;
      endcase
    end
  end

  assign head_s      = ev_valid ? mem_r[rd_ptr_r] : 10'd0;
  assign ev_valid    = (count_r != CNT_W'(0));
  assign ev_ext      = head_s[9];
  assign ev_break    = head_s[8];
  assign ev_code     = head_s[7:0];
  assign move_speed  = speed_r;
  assign err_parity  = err_parity_r;
  assign err_timeout = err_timeout_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_ps2_kbd_event_rx.sv
// Testbench for ps2_kbd_event_rx: drives PS/2 frames bit by bit, records
// delivered events and error pulses, and compares against expectations
// queued by each scenario task.
module tb_ps2_kbd_event_rx;

  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, speed_up, speed_dn, ev_ready;
  logic       ev_valid, ev_ext, ev_break, err_parity, err_timeout, overflow;
  logic [7:0] ev_code;
  logic [2:0] move_speed;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int par_cnt = 0, tmo_cnt = 0, ovf_cnt = 0, tmo_cyc = 0;
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];

  ps2_kbd_event_rx #(
    .FILTER_LEN(2), .TIMEOUT_CYCLES(100), .FIFO_DEPTH(4),
    .HOLD_BASE(1000), .HOLD_STEP(100), .SPEED_W(3), .SPEED_INIT(4)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .speed_up(speed_up), .speed_dn(speed_dn),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code),
    .ev_ext(ev_ext), .ev_break(ev_break), .move_speed(move_speed),
    .err_parity(err_parity), .err_timeout(err_timeout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record delivered events and error pulses away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ev_valid === 1'b1 && ev_ready === 1'b1) obs_q.push_back({ev_ext, ev_break, ev_code});
      if (err_parity === 1'b1) par_cnt <= par_cnt + 1;
      if (err_timeout === 1'b1) begin
        tmo_cnt <= tmo_cnt + 1;
        tmo_cyc <= cyc;
      end
      if (overflow === 1'b1) ovf_cnt <= ovf_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clk = 1'b0;
    tick(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par);
    logic p;
    p = (~^d) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(1'b1);
  endtask

  task automatic test_reset();
    int p0, t0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks += 6;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset ev_valid: got %b want 0", ev_valid); end
    if (ev_code !== 8'h00) begin errors++; $display("FAIL reset ev_code: got %h want 00", ev_code); end
    if (ev_ext !== 1'b0 || ev_break !== 1'b0) begin errors++; $display("FAIL reset ext/brk: got %b%b want 00", ev_ext, ev_break); end
    if (move_speed !== 3'd4) begin errors++; $display("FAIL reset speed: got %0d want 4", move_speed); end
    if (err_parity !== 1'b0 || err_timeout !== 1'b0) begin errors++; $display("FAIL reset err: got %b%b want 00", err_parity, err_timeout); end
    if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b want 0", overflow); end
    // Reset during a frame: the frame must vanish with no event and no timeout.
    p0 = par_cnt; t0 = tmo_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    ps2_data = 1'b1;
    tick(150);
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midreset events: got %0d want 0", obs_q.size()); end
    if (par_cnt != p0 || tmo_cnt != t0) begin errors++; $display("FAIL midreset errors: got par %0d tmo %0d want 0 0", par_cnt - p0, tmo_cnt - t0); end
    obs_q.delete();
  endtask

  task automatic test_single_frame();
    int p0, t0, o0;
    logic [9:0] e, o;
    p0 = par_cnt; t0 = tmo_cnt; o0 = ovf_cnt;
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0);
    tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL single count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL single event: got %h want %h", o, e); end
    end
    checks++;
    if (par_cnt != p0 || tmo_cnt != t0 || ovf_cnt != o0) begin errors++; $display("FAIL single errors: got %0d %0d %0d want 0 0 0", par_cnt - p0, tmo_cnt - t0, ovf_cnt - o0); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_prefix();
    logic [9:0] e, o;
    exp_q.push_back({1'b1, 1'b1, 8'h75});
    send_frame(8'hE0, 1'b0); tick(20);
    send_frame(8'hF0, 1'b0); tick(20);
    send_frame(8'h75, 1'b0); tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL prefix count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL prefix event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_parity();
    int p0;
    logic [9:0] e, o;
    p0 = par_cnt;
    send_frame(8'h1C, 1'b1); tick(20);
    checks++;
    if (par_cnt - p0 != 1) begin errors++; $display("FAIL parity pulses: got %0d want 1", par_cnt - p0); end
    exp_q.push_back({1'b0, 1'b0, 8'h1D});
    send_frame(8'h1D, 1'b0); tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL parity count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL parity event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_timeout();
    int t0, start_cyc, dly;
    logic [9:0] e, o;
    t0 = tmo_cnt;
    ps2_data = 1'b0;
    tick(HALF);
    ps2_clk = 1'b0;
    start_cyc = cyc;
    tick(HALF);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (tmo_cnt != t0) break;
    end
    dly = tmo_cyc - start_cyc;
    checks += 2;
    if (tmo_cnt - t0 != 1) begin errors++; $display("FAIL timeout pulses: got %0d want 1", tmo_cnt - t0); end
    if (dly < 100 || dly > 115) begin errors++; $display("FAIL timeout delay: got %0d want 100..115", dly); end
    tick(20);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL timeout events: got %0d want 0", obs_q.size()); end
    // A clean frame afterwards shows the receiver is back in idle.
    exp_q.push_back({1'b0, 1'b0, 8'h24});
    send_frame(8'h24, 1'b0); tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout recover count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL timeout recover event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_repeat_hold();
    logic [9:0] e, o;
    tick(1000);
    // Stop edges of consecutive frames are (88 + gap) cycles apart; W = 600.
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0); tick(212);
    send_frame(8'h1C, 1'b0); tick(312);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0); tick(20);
    exp_q.push_back({1'b0, 1'b1, 8'h1C});
    send_frame(8'hF0, 1'b0); tick(20);
    send_frame(8'h1C, 1'b0); tick(20);
    exp_q.push_back({1'b0, 1'b0, 8'h1C});
    send_frame(8'h1C, 1'b0); tick(30);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL hold count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL hold event: got %h want %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overflow_speed();
    int o0;
    logic [9:0] e, o;
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    ev_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b0, 1'b0, codes[i]});
      send_frame(codes[i], 1'b0); tick(20);
    end
    checks += 2;
    if (ev_valid !== 1'b1) begin errors++; $display("FAIL fifo valid: got %b want 1", ev_valid); end
    if (ovf_cnt != o0) begin errors++; $display("FAIL early overflow: got %0d want 0", ovf_cnt - o0); end
    send_frame(codes[4], 1'b0); tick(20);
    checks += 2;
    if (ovf_cnt - o0 != 1) begin errors++; $display("FAIL overflow pulses: got %0d want 1", ovf_cnt - o0); end
    if (ev_code !== 8'h15) begin errors++; $display("FAIL fifo head: got %h want 15", ev_code); end
    ev_ready = 1'b1;
    tick(20);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL drain count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL drain event: got %h want %h", o, e); end
    end
    checks++;
    if (ev_valid !== 1'b0) begin errors++; $display("FAIL drain empty: got %b want 0", ev_valid); end
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) begin speed_up = 1'b1; tick(1); speed_up = 1'b0; tick(1); end
    checks++;
    if (move_speed !== 3'd7) begin errors++; $display("FAIL speed sat up: got %0d want 7", move_speed); end
    for (int i = 0; i < 9; i++) begin speed_dn = 1'b1; tick(1); speed_dn = 1'b0; tick(1); end
    checks++;
    if (move_speed !== 3'd0) begin errors++; $display("FAIL speed sat dn: got %0d want 0", move_speed); end
    speed_up = 1'b1; tick(1); speed_up = 1'b0; tick(1);
    speed_up = 1'b1; speed_dn = 1'b1; tick(1); speed_up = 1'b0; speed_dn = 1'b0; tick(1);
    checks++;
    if (move_speed !== 3'd1) begin errors++; $display("FAIL speed both: got %0d want 1", move_speed); end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    speed_up = 1'b0; speed_dn = 1'b0; ev_ready = 1'b1;
    test_reset();
    test_single_frame();
    test_prefix();
    test_parity();
    test_timeout();
    test_repeat_hold();
    test_overflow_speed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
